// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered MIPS ALU control decoder with multi-cycle HI/LO sequencing.
// Latency: single-cycle/illegal ops give o_valid one cycle after accept; MULT/MULTU
// hold BUSY for MUL_LAT cycles, DIV/DIVU for DIV_LAT cycles, o_valid in the last one.
// Backpressure: o_ready is high only in IDLE; i_flush aborts BUSY (no o_valid) and
// blocks accept in IDLE.
//
// Build option: define ALU_CTRL_DIV_EN to support DIV/DIVU. Without it they decode
// as illegal single-cycle ops and no divide-latency logic exists.
//
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_valid / o_ready     instruction handshake (i_aluOp, i_func sampled on accept)
//   i_flush               abort current operation / block accept
//   o_valid               one-cycle result strobe, qualifies o_illegal
//   o_aluControl          decoded control word (held between operations)
//   o_multiCycle, o_busy  high while a HI/LO operation is sequencing
//   o_illegal             accepted opcode/func was unsupported
module alu_ctrl_seq #(
  parameter int CTRL_W  = 6,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [5:0]        i_aluOp,
  input  logic [5:0]        i_func,
  input  logic              i_flush,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_aluControl,
  output logic              o_multiCycle,
  output logic              o_busy,
  output logic              o_illegal
);

  // Parameter sanity, evaluated at elaboration only.
  if (CTRL_W < 6) begin : g_bad_ctrl_w
    $error("alu_ctrl_seq: CTRL_W must be >= 6");
  end
  if (MUL_LAT < 1) begin : g_bad_mul_lat
    $error("alu_ctrl_seq: MUL_LAT must be >= 1");
  end
  if (DIV_LAT < 1) begin : g_bad_div_lat
    $error("alu_ctrl_seq: DIV_LAT must be >= 1");
  end

`ifdef ALU_CTRL_DIV_EN
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
`else
  localparam int MAX_LAT = MUL_LAT;
`endif
  localparam int CNT_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lat_load;
  logic [CTRL_W-1:0] ctrl_q;
  logic             illegal_q;
  logic             pulse_q;
  logic             accept;
  logic             cnt_zero;

  logic [5:0]       dec_ctrl;
  logic             dec_illegal;
  logic             dec_multi;
`ifdef ALU_CTRL_DIV_EN
  logic             dec_div;
`endif

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  always_comb begin
    dec_ctrl    = 6'b000000;
    dec_illegal = 1'b0;
    dec_multi   = 1'b0;
`ifdef ALU_CTRL_DIV_EN
    dec_div     = 1'b0;
`endif
    case (i_aluOp)
      6'h08, 6'h09, 6'h23, 6'h2B: dec_ctrl = 6'b100000; // ADDI/ADDIU/LW/SW
      6'h04, 6'h05:               dec_ctrl = 6'b100010; // BEQ/BNE
      6'h0A:                      dec_ctrl = 6'b101010; // SLTI
      6'h0B:                      dec_ctrl = 6'b101011; // SLTIU
      6'h0D:                      dec_ctrl = 6'b100101; // ORI
      6'h0E:                      dec_ctrl = 6'b100110; // XORI
      6'h0C:                      dec_ctrl = 6'b100100; // ANDI
      6'h0F:                      dec_ctrl = 6'b111100; // LUI
      6'h00: begin
        case (i_func)
          // ADD..NOR, SLT, SLTU, SLLV, SRLV, SRAV: func passes through
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b100110, 6'b100111,
          6'b101010, 6'b101011,
          6'b000100, 6'b000110, 6'b000111: dec_ctrl = i_func;
          6'b011000, 6'b011001: begin        // MULT/MULTU
            dec_ctrl  = i_func;
            dec_multi = 1'b1;
          end
`ifdef ALU_CTRL_DIV_EN
          6'b011010, 6'b011011: begin        // DIV/DIVU
            dec_ctrl  = i_func;
            dec_multi = 1'b1;
            dec_div   = 1'b1;
          end
`endif
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Counter is loaded with LAT-1 so that counter==0 marks the final BUSY cycle.
  always_comb begin
`ifdef ALU_CTRL_DIV_EN
    lat_load = dec_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
`else
    lat_load = CNT_W'(MUL_LAT - 1);
`endif
  end

  assign accept   = i_valid && (state == IDLE) && !i_flush;
  assign cnt_zero = (cnt == '0);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state. Flush wins over counter expiry.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && dec_multi) state_nxt = BUSY;
      BUSY: if (i_flush || cnt_zero) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs. The multi-cycle o_valid is combinational so it lands in the
  // last BUSY cycle and can be suppressed by a same-cycle flush.
  always_comb begin
    o_ready      = (state == IDLE);
    o_busy       = (state == BUSY);
    o_multiCycle = (state == BUSY);
    o_valid      = pulse_q || ((state == BUSY) && cnt_zero && !i_flush);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt       <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      pulse_q <= accept && !dec_multi;
      // Control word is only replaced on accept, so it is retained through
      // flushes and idle periods.
      if (accept) begin
        ctrl_q    <= CTRL_W'(dec_ctrl);
        illegal_q <= dec_illegal;
      end
      if (accept && dec_multi) begin
        cnt <= lat_load;
      end else if (state == BUSY) begin
        cnt <= (i_flush || cnt_zero) ? '0 : cnt - CNT_W'(1);
      end
    end
  end

  assign o_aluControl = ctrl_q;
  assign o_illegal    = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
module tb_alu_ctrl_seq;

  logic       clk;
  logic       rst_n;
  logic       i_valid;
  logic       o_ready;
  logic [5:0] i_aluOp;
  logic [5:0] i_func;
  logic       i_flush;
  logic       o_valid;
  logic [5:0] o_aluControl;
  logic       o_multiCycle;
  logic       o_busy;
  logic       o_illegal;

  typedef struct packed {
    logic [5:0] ctrl;
    logic       ill;
    logic       mc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_ctrl_seq #(.CTRL_W(6), .MUL_LAT(4), .DIV_LAT(32)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_aluOp      (i_aluOp),
    .i_func       (i_func),
    .i_flush      (i_flush),
    .o_valid      (o_valid),
    .o_aluControl (o_aluControl),
    .o_multiCycle (o_multiCycle),
    .o_busy       (o_busy),
    .o_illegal    (o_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every o_valid strobe must match the oldest expected response.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && o_valid !== 1'b0) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got o_valid=%b expected none at %0t", o_valid, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_ctrl", {26'd0, o_aluControl}, {26'd0, e.ctrl});
        check("sb_illegal", {31'd0, o_illegal}, {31'd0, e.ill});
        check("sb_multicycle", {31'd0, o_multiCycle}, {31'd0, e.mc});
      end
    end
  end

  // Present one instruction for one edge (called just after a rising edge).
  task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                       input logic [5:0] ectrl, input logic eill);
    exp_t e;
    e.ctrl = ectrl;
    e.ill  = eill;
    e.mc   = 1'b0;
    i_valid = 1'b1;
    i_aluOp = op;
    i_func  = fn;
    sb.push_back(e);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_flush = 1'b0;
    i_aluOp = 6'h00;
    i_func  = 6'h00;

    // Reset held for two edges: all outputs cleared, ready high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {27'd0, o_valid, o_busy, o_multiCycle, o_illegal, 1'b0}, 32'd0);
    check("rst_ctrl", {26'd0, o_aluControl}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back single-cycle decodes.
    issue(6'h08, 6'h00, 6'h20, 1'b0);   // ADDI
    issue(6'h00, 6'h23, 6'h23, 1'b0);   // SUBU
    issue(6'h0F, 6'h00, 6'h3C, 1'b0);   // LUI
    issue(6'h04, 6'h00, 6'h22, 1'b0);   // BEQ
    issue(6'h0B, 6'h00, 6'h2B, 1'b0);   // SLTIU
    issue(6'h2B, 6'h00, 6'h20, 1'b0);   // SW
    issue(6'h0E, 6'h00, 6'h26, 1'b0);   // XORI
    issue(6'h00, 6'h07, 6'h07, 1'b0);   // SRAV
    issue(6'h00, 6'h27, 6'h27, 1'b0);   // NOR
    issue(6'h3F, 6'h00, 6'h00, 1'b1);   // illegal opcode
    issue(6'h00, 6'h08, 6'h00, 1'b1);   // JR func: not an ALU op
    @(posedge clk);
    #1;

    // MULT with i_valid held high: next instruction waits until ready returns.
    i_valid = 1'b1;
    i_aluOp = 6'h00;
    i_func  = 6'h18;
    e = '{ctrl: 6'h18, ill: 1'b0, mc: 1'b1};
    sb.push_back(e);
    @(posedge clk);                     // edge k: MULT accepted
    #1;
    i_aluOp = 6'h08;                    // ADDI waiting behind it
    i_func  = 6'h00;
    e = '{ctrl: 6'h20, ill: 1'b0, mc: 1'b0};
    sb.push_back(e);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("mult_busy", {31'd0, o_busy}, 32'd1);
      check("mult_ready", {31'd0, o_ready}, 32'd0);
      check("mult_valid_timing", {31'd0, o_valid}, (i == 4) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);                     // cycle k+5
    check("mult_done_ready", {31'd0, o_ready}, 32'd1);
    check("mult_done_busy", {31'd0, o_busy}, 32'd0);
    @(posedge clk);                     // ADDI accepted here
    #1;
    i_valid = 1'b0;
    @(posedge clk);
    #1;

`ifdef ALU_CTRL_DIV_EN
    // DIV flushed in its 10th BUSY cycle: no o_valid, control retained.
    i_valid = 1'b1;
    i_aluOp = 6'h00;
    i_func  = 6'h1A;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      check("div_busy", {31'd0, o_busy}, 32'd1);
      @(posedge clk);
      #1;
    end
    i_flush = 1'b1;
    @(negedge clk);
    check("div_busy_flush_cycle", {31'd0, o_busy}, 32'd1);
    check("div_no_valid", {31'd0, o_valid}, 32'd0);
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    @(negedge clk);
    check("div_flush_ready", {31'd0, o_ready}, 32'd1);
    check("div_flush_busy", {31'd0, o_busy}, 32'd0);
    check("div_flush_ctrl", {26'd0, o_aluControl}, 32'h1A);
    @(posedge clk);
    #1;
`else
    // DIVU without divide support: single-cycle illegal, never busy.
    issue(6'h00, 6'h1B, 6'h00, 1'b1);
    @(negedge clk);
    check("divu_not_busy", {31'd0, o_busy}, 32'd0);
    check("divu_ready", {31'd0, o_ready}, 32'd1);
    @(posedge clk);
    #1;
`endif

    // Flush in IDLE blocks accept; control word keeps its last value.
    issue(6'h0D, 6'h00, 6'h25, 1'b0);   // ORI
    i_valid = 1'b1;
    i_flush = 1'b1;
    i_aluOp = 6'h08;
    i_func  = 6'h00;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    @(negedge clk);
    check("idle_flush_no_valid", {31'd0, o_valid}, 32'd0);
    check("idle_flush_ctrl", {26'd0, o_aluControl}, 32'h25);
    @(posedge clk);
    #1;

    // Reset while busy with MULTU: everything cleared, no o_valid.
    i_valid = 1'b1;
    i_aluOp = 6'h00;
    i_func  = 6'h19;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    @(negedge clk);
    check("multu_busy", {31'd0, o_busy}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_outputs", {27'd0, o_valid, o_busy, o_multiCycle, o_illegal, o_ready}, 32'd1);
    check("midrst_ctrl", {26'd0, o_aluControl}, 32'd0);
    repeat (6) @(posedge clk);
    #1;

    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Registered, parametrised ALU control unit for the MIPS core that replaces the purely combinational decoder. It decodes opcode/function fields into an ALU control word behind a valid/ready handshake. It also sequences multi-cycle HI/LO operations (MULT/MULTU/DIV/DIVU), holding the control word and raising a busy stall for a configurable number of cycles. It sits between the main decoder and the ALU/multiplier-divider datapath.

## Interface

Parameters:
- CTRL_W, 6: ALU control word width; must be ≥6. Upper bits are zero-filled.
- MUL_LAT, 4: cycles in BUSY for MULT/MULTU; must be ≥1.
- DIV_LAT, 32: cycles in BUSY for DIV/DIVU; must be ≥1.

Ports:
- i_clk, input, 1: clock. All state changes on the rising edge.
- i_rst_n, input, 1: synchronous, active-low reset.
- i_valid, input, 1: an instruction is presented.
- o_ready, output, 1: the block can accept an instruction; high only in IDLE.
- i_aluOp, input, 6: instruction opcode field.
- i_func, input, 6: instruction function field.
- i_flush, input, 1: abort the current operation.
- o_valid, output, 1: result control is valid; one-cycle pulse.
- o_aluControl, output, CTRL_W: decoded ALU control word.
- o_multiCycle, output, 1: the current operation is MULT/MULTU/DIV/DIVU.
- o_busy, output, 1: pipeline stall request.
- o_illegal, output, 1: the accepted opcode/func is unsupported. Qualified by o_valid.

## Operation

- Accept occurs on the edge where i_valid && o_ready && !i_flush. Inputs are sampled only on accept.
- Decode rules:
  - ADDI(08)/ADDIU(09)/LW(23)/SW(2B) → 100000.
  - BEQ(04)/BNE(05) → 100010.
  - SLTI(0A) → 101010.
  - SLTIU(0B) → 101011.
  - ORI(0D) → 100101.
  - XORI(0E) → 100110.
  - ANDI(0C) → 100100.
  - LUI(0F) → 111100.
- R-type (00) passes func through unchanged for ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLLV, SRLV(000110), SRAV(000111).
- R-type multi-cycle ops: MULT(011000), MULTU(011001), DIV(011010), DIVU(011011). Func is passed through and o_multiCycle=1.
- Any other opcode, or an unlisted func: o_aluControl=0, o_illegal=1.
- States:
  - IDLE: accept single-cycle or illegal op → stay in IDLE; o_valid pulses the next cycle. Accept multi-cycle op → BUSY; counter loaded with LAT−1.
  - BUSY: o_busy=1, o_ready=0, o_aluControl held. When counter==0: o_valid=1 this cycle, next state IDLE. Otherwise decrement.
- i_flush:
  - In BUSY: go to IDLE next edge, no o_valid, o_busy deasserts the next cycle, o_aluControl is retained.
  - In IDLE: blocks accept.
  - Flush takes priority over counter expiry.
- o_aluControl holds its last value when no operation is active.

## Timing

- Reset, while i_rst_n=0 at an edge: state=IDLE, counter=0, o_aluControl=0, o_valid=0, o_multiCycle=0, o_busy=0, o_illegal=0; o_ready=1 after the reset edge.
- Single-cycle or illegal op accepted at edge k: o_valid=1 during cycle k+1 only, with control and o_illegal valid. Back-to-back accepts are allowed every cycle.
- Multi-cycle op with latency L accepted at edge k:
  - o_busy=1 and o_multiCycle=1 during cycles k+1 through k+L.
  - o_valid=1 during cycle k+L.
  - o_ready=1 from cycle k+L+1.
- L=1: BUSY for exactly one cycle, with o_valid in that same cycle.
- Reset mid-BUSY: IDLE immediately, all outputs cleared, no o_valid.
- Counter width is clog2(max(MUL_LAT,DIV_LAT)) with a minimum of 1 bit; no wrap-around occurs.

## Configuration

- ALU_CTRL_DIV_EN defined: DIV/DIVU are supported per DIV_LAT.
- ALU_CTRL_DIV_EN undefined: DIV/DIVU decode as illegal (o_illegal=1, o_aluControl=0, single-cycle). The DIV_LAT parameter is ignored and no divide-latency logic is built.

## Test plan

- Reset: drive i_rst_n=0 for 2 cycles, then release → all outputs 0, o_ready=1.
- ADDI (i_aluOp=08) accepted at edge k → cycle k+1: o_valid=1, o_aluControl=100000, o_illegal=0. Then R-type SUBU (func 100011) on the next edge → 100011 one cycle later.
- MULT (00/011000), MUL_LAT=4, accepted at edge k → o_busy high k+1..k+4; o_valid only at k+4 with 011000; o_ready=0 throughout; i_valid held high gains no accept until k+5.
- DIV (00/011010), DIV_LAT=32, with i_flush asserted in the 10th BUSY cycle → IDLE next edge, no o_valid pulse, o_ready=1.
- Illegal opcode 3F, and R-type func 001000 → o_valid=1, o_illegal=1, o_aluControl=0.
- Build without ALU_CTRL_DIV_EN: DIVU (00/011011) → single-cycle o_valid with o_illegal=1 and o_busy never asserted.
